ws2812_tx: RTL
==============

// Module: ws2812_tx
// PURPOSE
//  Serialiser for the WS2812 chain. Reads 24-bit GRB pixels from the LED frame buffer that the FIFO-side
//  controller fills, and drives the single-wire WS2812 NRZ waveform on dout, MSB (G[7]) first.
//  One frame = num_leds pixels from address 0 upward, then a low reset/latch gap; frames start on request.
// PARAMETERS
//  ADDR_W     11    frame-buffer address width
//  T_BIT      62    clk cycles per data bit (1.24 us at 50 MHz)
//  T0H        20    high cycles for a '0' bit (0.40 us); must be < T1H < T_BIT
//  T1H        40    high cycles for a '1' bit (0.80 us)
//  T_RESET    3000  low cycles of latch gap after last pixel (60 us)
// PORTS
//  clk        in   1       system clock
//  rst        in   1       asynchronous reset, active high
//  start      in   1       single-cycle frame request; sampled only in IDLE
//  num_leds   in   ADDR_W  pixels per frame, captured on accepted start
//  rd_addr    out  ADDR_W  frame-buffer read address
//  rd_en      out  1       frame-buffer read strobe (one cycle per pixel)
//  rd_data    in   24      pixel {G,R,B}, valid exactly 1 clk after rd_en
//  dout       out  1       WS2812 data line
//  busy       out  1       high from accepted start until done
//  done       out  1       one-cycle pulse when latch gap completes
// BEHAVIOUR
//  Reset (async, any state): dout=0, busy=0, done=0, rd_en=0, rd_addr=0, state=IDLE, counters=0.
//  States: IDLE -> FETCH -> LOAD -> SEND -> LATCH -> IDLE.
//  IDLE: dout=0. start=1: capture num_leds into n_left, busy<=1; n_left==0 -> LATCH, else -> FETCH.
//  FETCH: rd_addr=0, rd_en=1 for one cycle -> LOAD.
//  LOAD: shift_reg<=rd_data, bit_cnt<=23, bit timer<=0 -> SEND (2 clk from start to first dout rise).
//  SEND: per bit, timer counts 0..T_BIT-1; dout=1 while timer < (shift_reg[23] ? T1H : T0H), else 0.
//   At timer==T_BIT-1: shift left, bit_cnt--, timer<=0. Bit periods are back-to-back, no gaps.
//  Prefetch: at first cycle of bit 23 of pixel k, if k+1 < num_leds, issue rd_en with rd_addr=k+1;
//   capture rd_data next cycle into next_reg. After bit 0 of pixel k, shift_reg<=next_reg with no gap.
//  After bit 0 of last pixel -> LATCH with timer<=0. Pixel-to-pixel waveform is seamless.
//  LATCH: dout=0 for T_RESET cycles; then done=1 for one cycle, busy<=0 -> IDLE.
//  start while busy is ignored (no queuing). num_leds changes mid-frame have no effect.
//  rd_addr holds last issued value between reads. rd_addr never exceeds num_leds-1.
//  Timers sized ceil(log2(max(T_BIT,T_RESET)+1)); all comparisons unsigned.
//  Reset mid-frame: dout drops low asynchronously; the next start re-sends the whole frame from addr 0.
// TESTING
//  1 LED, mem[0]=24'hFF0000, start -> 8 highs of 40 clk then 16 highs of 20 clk, each bit 62 clk;
//   dout low 3000 clk, done pulses once, busy falls in the same cycle.
//  3 LEDs {0xAAAAAA, 0x555555, 0x000001} -> 72 contiguous bit periods with correct pattern;
//   rd_en exactly 3 times, addr 0,1,2; no extra low gap between pixels.
//  num_leds=0, start -> no rd_en, dout stays 0, done after T_RESET+1..2 clk.
//  start pulsed again mid-frame -> ignored; only one done; waveform unchanged.
//  Assert rst during bit 10 of LED 1 of 3 -> dout=0 immediately, busy=0.
//   Next start -> frame restarts at addr 0.
//  Back-to-back start in cycle after done -> second frame identical, 2-clk start-to-first-rise latency.

Source files
------------

// File: rtl/ws2812_tx.sv
// WS2812 single-wire NRZ serialiser: streams num_leds GRB pixels from the frame buffer,
// MSB first, then holds the line low for the latch gap before pulsing done.
module ws2812_tx #(
    parameter int ADDR_W  = 11,
    parameter int T_BIT   = 62,
    parameter int T0H     = 20,
    parameter int T1H     = 40,
    parameter int T_RESET = 3000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_leds,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [23:0]       rd_data,
    output logic              dout,
    output logic              busy,
    output logic              done
);
    localparam int TMAX = (T_BIT > T_RESET) ? T_BIT : T_RESET;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] BIT_LAST = TW'(T_BIT - 1);
    localparam logic [TW-1:0] RST_LAST = TW'(T_RESET - 1);
    localparam logic [TW-1:0] T0H_C    = TW'(T0H);
    localparam logic [TW-1:0] T1H_C    = TW'(T1H);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;

    logic [2:0]        state_q,   state_d;
    logic [TW-1:0]     timer_q,   timer_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [23:0]       shift_q,   shift_d;
    logic [23:0]       next_q,    next_d;
    logic              pf_q,      pf_d;
    logic [ADDR_W-1:0] pix_q,     pix_d;
    logic [ADDR_W-1:0] num_q,     num_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;

    logic [ADDR_W:0]   pix_next;
    logic              more_pix;
    logic              prefetch;

    // One spare bit keeps pix+1 from wrapping when the frame fills the whole address space.
    assign pix_next = {1'b0, pix_q} + 1'b1;
    assign more_pix = pix_next < {1'b0, num_q};
    assign prefetch = (state_q == S_SEND) && (bit_cnt_q == 5'd23) && (timer_q == '0) && more_pix;

    assign rd_en   = (state_q == S_FETCH) || prefetch;
    assign rd_addr = prefetch ? pix_next[ADDR_W-1:0] : addr_q;
    assign dout    = (state_q == S_SEND) && (timer_q < (shift_q[23] ? T1H_C : T0H_C));
    assign busy    = busy_q;
    assign done    = done_q;

    always_comb begin
        // NOTE: every next-state signal gets a default here so no path leaves one unassigned (no latches).
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        next_d    = pf_q ? rd_data : next_q;
        pf_d      = prefetch;
        pix_d     = pix_q;
        num_d     = num_q;
        addr_d    = addr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d   = num_leds;
                    busy_d  = 1'b1;
                    addr_d  = '0;
                    pix_d   = '0;
                    timer_d = '0;
                    state_d = (num_leds == '0) ? S_LATCH : S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                shift_d   = rd_data;
                bit_cnt_d = 5'd23;
                timer_d   = '0;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (prefetch) addr_d = pix_next[ADDR_W-1:0];
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    if (bit_cnt_q != 5'd0) begin
                        shift_d   = {shift_q[22:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end else if (more_pix) begin
                        shift_d   = next_q;
                        bit_cnt_d = 5'd23;
                        pix_d     = pix_next[ADDR_W-1:0];
                    end else begin
                        state_d = S_LATCH;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (timer_q == RST_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the datapath is reset too so a mid-frame reset leaves no stale pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            next_q    <= '0;
            pf_q      <= 1'b0;
            pix_q     <= '0;
            num_q     <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            next_q    <= next_d;
            pf_q      <= pf_d;
            pix_q     <= pix_d;
            num_q     <= num_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end
endmodule
